// File: rtl/hamming_pkg.sv
// Types and constants shared by the serial receiver and the Hamming(7,4) decoder stage.
package hamming_pkg;

  localparam int CW_WIDTH   = 7;
  localparam int DATA_WIDTH = 4;
  localparam int CNT_WIDTH  = $clog2(CW_WIDTH);

  typedef logic [CW_WIDTH-1:0]  codeword_t;
  typedef logic [CNT_WIDTH-1:0] bit_cnt_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(CW_WIDTH - 1);

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for an asynchronous level input; resets to 1 so an idle-high
// line never looks like a start bit straight out of reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hamming_serial_rx.sv
// UART-style deserializer feeding the Hamming(7,4) decoder: start bit, 7 data bits LSB
// first, stop bit. Codewords are passed bit-exact; a bad stop bit discards the frame.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sample_tick,
  input  logic      serial_in,
  output codeword_t codeword_out,
  output logic      codeword_valid,
  output logic      frame_error,
  output logic      busy
);

  logic      rx_s;
  rx_state_t state_q, state_d;
  bit_cnt_t  bit_cnt_q, bit_cnt_d;
  codeword_t shift_q, shift_d;
  codeword_t codeword_q, codeword_d;
  logic      valid_q, valid_d;
  logic      error_q, error_d;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d_i(serial_in),
    .q_o(rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      codeword_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      codeword_q <= codeword_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Everything holds between ticks; the pulse flags default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    codeword_d = codeword_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
          end
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (rx_s) begin
            codeword_d = shift_q;
            valid_d    = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: begin
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  assign codeword_out   = codeword_q;
  assign codeword_valid = valid_q;
  assign frame_error    = error_q;
  assign busy           = (state_q != RX_IDLE);

endmodule
